piso_tx: RTL and testbench
==========================

Name: piso_tx

Overview:
- Parallel-in, serial-out shift transmitter. It is the transmit end of the serial link whose receive end is the existing 4-bit serial-in/parallel-out register.
- Accepts a WIDTH-bit word through a valid/ready load handshake, then drives it out one bit per clock on dout, with dout_valid qualifying each bit.
- Default MSB-first order, so a word streamed into the SIPO receiver reappears unchanged on its parallel output after WIDTH clocks.
- Supports back-to-back words with no idle gap.

Parameters:
- WIDTH, 4, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = transmit pin[WIDTH-1] first; 0 = transmit pin[0] first.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset.
- pin  input  WIDTH  parallel word to send; sampled only on an accepted load.
- load_valid  input  1  requester presents a word on pin.
- load_ready  output  1  block can accept a word this cycle.
- dout  output  1  serial data bit.
- dout_valid  output  1  dout carries a word bit this cycle.
- busy  output  1  a word is in flight (state SHIFT).
- done  output  1  one-cycle pulse coinciding with the last bit of a word.

Behaviour:
- One clock; reset is asynchronous and active-high.
- While rst=1:
  - state=IDLE, shift register=0, bit counter=0.
  - dout=0, dout_valid=0, busy=0, done=0, load_ready=0.
- Reset asserted mid-word aborts the word immediately; no partial bits resume after release.
- States: IDLE, SHIFT.
- load_ready is combinational: 1 when state=IDLE and rst=0, or when state=SHIFT and the counter is at the last bit (counter==WIDTH-1).
- Accept = load_valid && load_ready at a rising edge.
  - pin is captured into the shift register.
  - Counter is cleared to 0.
  - State becomes SHIFT.
- In SHIFT, every cycle:
  - dout = the current head bit (bit WIDTH-1 if MSB_FIRST, else bit 0); dout_valid=1; busy=1.
  - At each edge the register shifts toward the head, filling with 0, and the counter increments.
- Latency: first bit appears on dout the cycle after the accepting edge. Bit k (0-based) appears k+1 cycles after accept. A word occupies exactly WIDTH consecutive valid cycles.
- done=1 exactly in the cycle where counter==WIDTH-1 and state=SHIFT.
- At the edge ending the last bit:
  - If an accept occurs, the new word is loaded and SHIFT continues, so the next cycle carries its first bit (gapless).
  - Otherwise state→IDLE.
- In IDLE: dout=0, dout_valid=0, busy=0, done=0.
- load_valid in SHIFT before the last bit: not accepted (load_ready=0), no effect; the requester must hold pin and load_valid until accepted.
- pin changes while not accepting: ignored.
- Counter width: $clog2(WIDTH); it never exceeds WIDTH-1.
- All outputs except load_ready are registered or decoded from registered state only; dout must not depend combinationally on pin.

Decomposition:
- Shared package (serial_link_pkg):
  - state enum {IDLE, SHIFT}.
  - default link width constant SER_WIDTH=4, also to be used by the receiver.
- No sub-module needed. Shift register, counter and FSM form one flat block of about 150 lines.
- The bench instantiates sipo_4bit as the loopback receiver.

Test Plan:
- Reset then idle, WIDTH=4, load_valid=0 for 10 cycles -> dout_valid=0, dout=0, busy=0, load_ready=1 throughout.
- Single word, pin=4'b1011, one-cycle load_valid -> next 4 cycles dout=1,0,1,1 with dout_valid=1; done=1 only on the 4th; then IDLE with load_ready=1.
- Loopback into sipo_4bit (din=dout), pin=4'b1011 -> sipo pout==4'b1011 on the cycle after the last bit; repeat with 4'b0110 -> pout==4'b0110.
- Back-to-back: load_valid held with 4'b1011 then 4'b0110 (switched after the first accept) -> 8 contiguous valid bits 1,0,1,1,0,1,1,0; second accept happens in the done cycle; no gap; done pulses at bits 4 and 8.
- Load while busy: load_valid pulsed during bit 2 of 4'b1100 -> not accepted, stream 1,1,0,0 uninterrupted, no extra word follows.
- Reset mid-word: rst asserted asynchronously during bit 2 of 4'b1111 -> dout, dout_valid and busy drop to 0 in the same cycle without waiting for an edge; after release a new 4'b0001 sends 0,0,0,1 cleanly. Repeat with MSB_FIRST=0 -> 4'b0001 sends 1,0,0,0.

Source files
------------

// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial link: transmitter FSM states and the
// default link width used by both the transmitter and the receiver.
package serial_link_pkg;

  // Default word width of the link; the SIPO receiver is sized from this too.
  localparam int SER_WIDTH = 4;

  // Transmitter control states.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } link_state_e;

endpackage : serial_link_pkg

// File: rtl/sipo_4bit.sv
// Serial-in / parallel-out receiver for the link. It shifts every clock,
// inserting at the LSB, so an MSB-first word appears unchanged on pout one
// edge after its last bit.
module sipo_4bit
  import serial_link_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  output logic [SER_WIDTH-1:0] pout
);

  logic [SER_WIDTH-1:0] pout_q;

  // Shift register: newest bit enters at bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pout_q <= '0;
    end else begin
      pout_q <= {pout_q[SER_WIDTH-2:0], din};
    end
  end

  assign pout = pout_q;

endmodule : sipo_4bit

// File: rtl/piso_tx.sv
// Parallel-in / serial-out transmitter. A word is accepted through a
// valid/ready handshake and sent one bit per clock with dout_valid set.
// A new word can be accepted during the last bit of the current one, so
// consecutive words stream with no idle cycle between them.
module piso_tx
  import serial_link_pkg::*;
#(
  parameter int WIDTH     = SER_WIDTH,  // 2..32
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  link_state_e      state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic last_bit;
  logic accept;
  logic head_bit;

  assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_CNT);
  assign accept   = load_valid && load_ready;
  assign head_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

  // State register: FSM state, shift register and bit counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: accept a word, shift toward the head, or fall idle.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = SHIFT;
      shreg_d = pin;
      cnt_d   = '0;
    end else if (state_q == SHIFT) begin
      shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                          : {1'b0, shreg_q[WIDTH-1:1]};
      if (last_bit) begin
        // Word finished with nothing queued: park the counter at zero so it
        // never runs past WIDTH-1.
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Output decode: serial outputs come from registered state only; the
  // ready flag also looks at rst so nothing is accepted while in reset.
  always_comb begin
    load_ready = !rst && ((state_q == IDLE) || last_bit);
    dout       = (state_q == SHIFT) ? head_bit : 1'b0;
    dout_valid = (state_q == SHIFT);
    busy       = (state_q == SHIFT);
    done       = last_bit;
  end

endmodule : piso_tx

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: an MSB-first instance looped back into
// sipo_4bit and an LSB-first instance driven with the same stimulus.
module tb_piso_tx;
  import serial_link_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid;
  logic [3:0] pin;

  logic       load_ready, dout, dout_valid, busy, done;
  logic       load_ready_l, dout_l, dout_valid_l, busy_l, done_l;
  logic [3:0] pout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .pin        (pin),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .done       (done)
  );

  piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk        (clk),
    .rst        (rst),
    .pin        (pin),
    .load_valid (load_valid),
    .load_ready (load_ready_l),
    .dout       (dout_l),
    .dout_valid (dout_valid_l),
    .busy       (busy_l),
    .done       (done_l)
  );

  sipo_4bit rx (
    .clk  (clk),
    .rst  (rst),
    .din  (dout),
    .pout (pout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a word for exactly one accepting edge, then scramble pin.
  // Called at posedge+1 while both transmitters are ready.
  task automatic load_word(input logic [3:0] w);
    pin        = w;
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    pin        = ~w;
  endtask

  // Check four bits; seq[3] is the first bit expected on the wire.
  // poke_k >= 0 pulses load_valid during that bit, which must be refused.
  task automatic expect_word(input string tag, input logic [3:0] seq_m,
                             input logic [3:0] seq_l, input int poke_k);
    for (int k = 0; k < 4; k++) begin
      if (k == poke_k) begin
        load_valid = 1'b1;
        pin        = 4'b1010;
      end
      @(negedge clk);
      check({tag, " dout"},       32'(dout),         32'(seq_m[3-k]));
      check({tag, " dout_valid"}, 32'(dout_valid),   32'd1);
      check({tag, " busy"},       32'(busy),         32'd1);
      check({tag, " done"},       32'(done),         32'(k == 3));
      check({tag, " dout_lsb"},   32'(dout_l),       32'(seq_l[3-k]));
      check({tag, " done_lsb"},   32'(done_l),       32'(k == 3));
      if (k == poke_k) check({tag, " load_ready"}, 32'(load_ready), 32'd0);
      @(posedge clk); #1;
      if (k == poke_k) load_valid = 1'b0;
    end
  endtask

  task automatic expect_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, " dout"},           32'(dout),         32'd0);
      check({tag, " dout_valid"},     32'(dout_valid),   32'd0);
      check({tag, " busy"},           32'(busy),         32'd0);
      check({tag, " done"},           32'(done),         32'd0);
      check({tag, " load_ready"},     32'(load_ready),   32'd1);
      check({tag, " dout_valid_lsb"}, 32'(dout_valid_l), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b2b_m;
    logic [7:0] b2b_l;
    b2b_m = 8'b1011_0110;
    b2b_l = 8'b1101_0110;

    rst        = 1'b1;
    load_valid = 1'b0;
    pin        = 4'b0000;

    // Reset state, with a word offered to prove it is refused in reset.
    @(posedge clk); #1;
    load_valid = 1'b1;
    pin        = 4'b1111;
    @(posedge clk); #1;
    check("rst load_ready", 32'(load_ready), 32'd0);
    check("rst dout",       32'(dout),       32'd0);
    check("rst dout_valid", 32'(dout_valid), 32'd0);
    check("rst busy",       32'(busy),       32'd0);
    check("rst done",       32'(done),       32'd0);
    check("rst pout",       32'(pout),       32'd0);
    load_valid = 1'b0;
    rst        = 1'b0;

    expect_idle("idle", 10);

    // Single word plus loopback.
    load_word(4'b1011);
    expect_word("w1011", 4'b1011, 4'b1101, -1);
    @(negedge clk);
    check("loop1011 pout",       32'(pout),       32'hb);
    check("loop1011 load_ready", 32'(load_ready), 32'd1);
    check("loop1011 dout_valid", 32'(dout_valid), 32'd0);
    @(posedge clk); #1;

    load_word(4'b0110);
    expect_word("w0110", 4'b0110, 4'b0110, -1);
    @(negedge clk);
    check("loop0110 pout", 32'(pout), 32'h6);
    @(posedge clk); #1;

    // Back-to-back: second word accepted in the done cycle of the first.
    pin        = 4'b1011;
    load_valid = 1'b1;
    @(posedge clk); #1;
    pin = 4'b0110;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("b2b dout",       32'(dout),       32'(b2b_m[7-k]));
      check("b2b dout_valid", 32'(dout_valid), 32'd1);
      check("b2b done",       32'(done),       32'((k == 3) || (k == 7)));
      check("b2b load_ready", 32'(load_ready), 32'((k == 3) || (k == 7)));
      check("b2b dout_lsb",   32'(dout_l),     32'(b2b_l[7-k]));
      @(posedge clk); #1;
      if (k == 3) load_valid = 1'b0;
    end
    @(negedge clk);
    check("b2b pout",       32'(pout),       32'h6);
    check("b2b dout_valid", 32'(dout_valid), 32'd0);
    @(posedge clk); #1;
    expect_idle("b2b idle", 2);

    // Load attempt during the second bit must be ignored.
    load_word(4'b1100);
    expect_word("busy", 4'b1100, 4'b0011, 1);
    expect_idle("no extra", 3);

    // Asynchronous reset mid-word.
    load_word(4'b1111);
    @(negedge clk);
    check("mid bit1 dout", 32'(dout), 32'd1);
    @(posedge clk); #1;
    #2;
    check("mid bit2 dout", 32'(dout), 32'd1);
    check("mid bit2 busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("async dout",           32'(dout),         32'd0);
    check("async dout_valid",     32'(dout_valid),   32'd0);
    check("async busy",           32'(busy),         32'd0);
    check("async load_ready",     32'(load_ready),   32'd0);
    check("async dout_lsb",       32'(dout_l),       32'd0);
    check("async dout_valid_lsb", 32'(dout_valid_l), 32'd0);
    check("async busy_lsb",       32'(busy_l),       32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    expect_idle("post rst", 1);

    load_word(4'b0001);
    expect_word("rst 0001", 4'b0001, 4'b1000, -1);
    expect_idle("end", 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_piso_tx
